// File: rtl/muldiv_iter_e_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
// master drives the request side, slave (the unit) returns busy, done and the result.
interface muldiv_iter_e_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rd_in;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, rs1, rs2, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, rs1, rs2, rd_in, flush,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_iter_e.sv
// Iterative RV32M multiply/divide: radix-2 loop, done one cycle after edge N+32 (N+0 for divide corner cases).
// No queuing: start is ignored while busy; flush aborts in any state without a done pulse.
module muldiv_iter_e #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            reset,
  muldiv_iter_e_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic       neg_q;
    logic       neg_a;
  } ctl_t;

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);

  state_t            state, state_next;
  ctl_t              ctl;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   operand;
  logic [2*XLEN-1:0] work, work_next;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  logic            accept, is_div, sgn_a, sgn_b, neg1, neg2;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] mag1, mag2, special_res;

  always_comb begin
    accept   = bus.start && !bus.flush && (state == IDLE);
    is_div   = bus.funct3[2];
    sgn_a    = is_div ? !bus.funct3[0] : (bus.funct3 != 3'b011);
    sgn_b    = is_div ? !bus.funct3[0] : !bus.funct3[1];
    neg1     = sgn_a && bus.rs1[XLEN-1];
    neg2     = sgn_b && bus.rs2[XLEN-1];
    mag1     = neg1 ? -bus.rs1 : bus.rs1;
    mag2     = neg2 ? -bus.rs2 : bus.rs2;
    div_zero = is_div && (bus.rs2 == '0);
    div_ovf  = is_div && !bus.funct3[0] && (bus.rs1 == INT_MIN) && (bus.rs2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = bus.funct3[1] ? bus.rs1 : '1;
    else          special_res = bus.funct3[1] ? '0 : INT_MIN;
  end

  // work holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem, quo, rem;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    mul_sum   = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    div_shift = work[2*XLEN-1:XLEN-1];
    div_ge    = div_shift >= {1'b0, operand};
    div_rem   = div_ge ? (div_shift[XLEN-1:0] - operand) : div_shift[XLEN-1:0];
    work_next = ctl.op[2] ? {div_rem, work[XLEN-2:0], div_ge} : {mul_sum, work[XLEN-1:1]};
    prod_fix  = ctl.neg_q ? -work_next : work_next;
    quo       = work_next[XLEN-1:0];
    rem       = work_next[2*XLEN-1:XLEN];
    if (ctl.op[2])               final_res = ctl.op[1] ? (ctl.neg_a ? -rem : rem) : (ctl.neg_q ? -quo : quo);
    else if (ctl.op[1:0] == 2'b00) final_res = prod_fix[XLEN-1:0];
    else                         final_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = special ? DONE : CALC;
      CALC:    if (cnt == LAST_CNT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl      <= '0;
      cnt      <= '0;
      operand  <= '0;
      work     <= '0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (accept) begin
      ctl <= '{op: bus.funct3, neg_q: neg1 ^ neg2, neg_a: neg1};
      rd_q <= bus.rd_in;
      cnt  <= '0;
      if (special) begin
        result_q <= special_res;
        rd_out_q <= bus.rd_in;
      end else if (is_div) begin
        operand <= mag2;
        work    <= {{XLEN{1'b0}}, mag1};
      end else begin
        operand <= mag1;
        work    <= {{XLEN{1'b0}}, mag2};
      end
    end else if (state == CALC && !bus.flush) begin
      work <= work_next;
      cnt  <= cnt + CNT_W'(1);
      if (cnt == LAST_CNT) begin
        result_q <= final_res;
        rd_out_q <= rd_q;
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_iter_e.sv
// Bench for muldiv_iter_e: directed vector table, random ops against a behavioural model, control corner cases.
module tb_muldiv_iter_e;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_iter_e_if #(.XLEN(32)) bus ();
  muldiv_iter_e #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub_s;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    ub_s = {32'b0, b};
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub_s; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Drives a request in the current cycle; the caller sits just after a negedge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    bus.funct3 = f;
    bus.rs1    = a;
    bus.rs2    = b;
    bus.rd_in  = rd;
    bus.start  = 1'b1;
    e.res = model(f, a, b);
    e.rd  = rd;
    e.lat = lat_of(f, a, b);
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int poke);
    exp_t e;
    bit seen = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        check({name, "_busy"}, 32'(bus.busy), 32'd1);
      end
      if (i == poke) begin
        bus.start  = 1'b1;
        bus.funct3 = 3'b101;
        bus.rs1    = 32'd100;
        bus.rs2    = 32'd7;
        bus.rd_in  = 5'd7;
      end else if (i == poke + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        seen = 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s_sb actual=done required=no_pending", name);
        end else begin
          e = exp_q.pop_front();
          check({name, "_res"}, bus.result, e.res);
          check({name, "_rd"}, 32'(bus.rd_out), 32'(e.rd));
          check({name, "_lat"}, 32'(i), 32'(e.lat));
          last_res = e.res;
          last_rd  = e.rd;
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      @(negedge clk);
      check({name, "_done_low"}, 32'(bus.done), 32'd0);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_done"}, 32'(bus.done), 32'd0);
    check({name, "_result"}, bus.result, 32'd0);
    check({name, "_rd_out"}, 32'(bus.rd_out), 32'd0);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t tbl[12];
    int   done_cnt;
    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
    tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 33};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 33};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 33};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 33};
    tbl[6]  = '{3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        33};
    tbl[7]  = '{3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         33};
    tbl[8]  = '{3'd5, 32'h1234,       32'd0,         5'd13, 32'hFFFF_FFFF, 1};
    tbl[9]  = '{3'd6, 32'h1234,       32'd0,         5'd14, 32'h1234,      1};
    tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1};
    tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h0,         1};

    bus.start = 0; bus.flush = 0; bus.funct3 = 0; bus.rs1 = 0; bus.rs2 = 0; bus.rd_in = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Each issue lands in the cycle right after the previous done, so these also run back-to-back.
    for (int i = 0; i < 12; i++) begin
      exp_t e;
      issue(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd);
      e = exp_q.pop_back();
      e.res = tbl[i].exp;
      e.lat = tbl[i].lat;
      exp_q.push_back(e);
      wait_done($sformatf("vec%0d", i), 0);
    end

    for (int i = 0; i < 24; i++) begin
      issue(3'($urandom_range(0, 7)), rand_val(), rand_val(), 5'($urandom_range(0, 31)));
      wait_done($sformatf("rnd%0d", i), 0);
    end

    issue(3'd0, 32'h1111, 32'd3, 5'd9);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    exp_q.delete();
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_done", 32'(bus.done), 32'd0);
    check("flush_result", bus.result, last_res);
    check("flush_rd_out", 32'(bus.rd_out), 32'(last_rd));
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("flush_no_done", 32'(done_cnt), 32'd0);

    issue(3'd5, 32'd50, 32'd5, 5'd4);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    exp_q.delete();
    check("flush_start_busy", 32'(bus.busy), 32'd0);

    issue(3'd0, 32'h10, 32'h20, 5'd3);
    wait_done("start_busy", 5);

    issue(3'd5, 32'd1000, 32'd3, 5'd2);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    reset = 1'b0;
    exp_q.delete();
    issue(3'd0, 32'd3, 32'd4, 5'd1);
    wait_done("post_reset", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
